// File: rtl/btle_rx_pdu_streamer.sv
// Reads a decoded BLE PDU (2 header octets + payload) out of the RX octet RAM and
// streams it as bytes over valid/ready, with CRC-drop filtering and saturating statistics.
module btle_rx_pdu_streamer #(
  parameter int MEM_RD_LATENCY = 1,
  parameter bit DROP_BAD_CRC   = 1'b1,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_decode_end,
  input  logic                 rx_crc_ok,
  input  logic [2:0]           rx_best_phase,
  input  logic [6:0]           rx_payload_length,
  output logic [5:0]           rx_pdu_octet_mem_addr,
  input  logic [7:0]           rx_pdu_octet_mem_data,
  input  logic                 flush,
  output logic [7:0]           m_data,
  output logic                 m_valid,
  output logic                 m_last,
  input  logic                 m_ready,
  output logic                 m_crc_ok,
  output logic [2:0]           m_best_phase,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] cnt_ok,
  output logic [CNT_WIDTH-1:0] cnt_drop,
  output logic [CNT_WIDTH-1:0] cnt_overrun
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (v == {CNT_WIDTH{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

  state_t                    state_r;
  logic [5:0]                addr_r;
  logic [5:0]                last_addr_r;
  logic                      crc_r;
  logic [2:0]                phase_r;
  logic [MEM_RD_LATENCY-1:0] vld_pipe_r;
  logic [MEM_RD_LATENCY-1:0] last_pipe_r;
  logic [7:0]                hd_data_r;
  logic                      hd_last_r;
  logic                      hd_vld_r;
  logic [7:0]                tl_data_r;
  logic                      tl_last_r;
  logic                      tl_vld_r;
  logic [CNT_WIDTH-1:0]      cnt_ok_r;
  logic [CNT_WIDTH-1:0]      cnt_drop_r;
  logic [CNT_WIDTH-1:0]      cnt_overrun_r;

  logic [7:0] len_sum_s;
  logic [5:0] last_addr_s;
  logic [2:0] inflight_s;
  logic [2:0] occ_s;
  logic       pop_s;
  logic       wr_en_s;
  logic       wr_last_s;
  logic       issue_s;
  logic       issue_last_s;
  logic       accept_s;
  logic       drop_s;
  logic       overrun_s;
  logic       done_s;

  // Header is always 2 octets; anything beyond the 64-octet RAM is clamped away.
  assign len_sum_s    = {1'b0, rx_payload_length} + 8'd2;
  assign last_addr_s  = (len_sum_s >= 8'd64) ? 6'd63 : (len_sum_s[5:0] - 6'd1);

  assign pop_s        = hd_vld_r & m_ready;
  assign wr_en_s      = vld_pipe_r[MEM_RD_LATENCY-1];
  assign wr_last_s    = last_pipe_r[MEM_RD_LATENCY-1];
  assign occ_s        = {2'b00, hd_vld_r} + {2'b00, tl_vld_r};
  assign issue_last_s = (addr_r == last_addr_r);

  // Count reads that have been issued but whose data has not yet entered the FIFO.
  always_comb begin
    inflight_s = 3'd0;
    for (int i = 0; i < MEM_RD_LATENCY; i++) begin
      inflight_s = inflight_s + {2'b00, vld_pipe_r[i]};
    end
  end

  // A pop this cycle frees a slot, which keeps the stream gap-free at 1 byte/cycle.
  assign issue_s   = (state_r == ST_RUN) & ~flush & ((occ_s + inflight_s) < (3'd2 + {2'b00, pop_s}));
  assign accept_s  = (state_r == ST_IDLE) & rx_decode_end & ~flush & (rx_crc_ok | ~DROP_BAD_CRC);
  assign drop_s    = (state_r == ST_IDLE) & rx_decode_end & ~flush & ~rx_crc_ok & DROP_BAD_CRC;
  assign overrun_s = (state_r != ST_IDLE) & rx_decode_end & ~flush;
  assign done_s    = (state_r == ST_DRAIN) & pop_s & hd_last_r & ~flush;

  // Packet sequencer: accepts a packet, walks the read address, then waits for the drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      addr_r      <= 6'd0;
      last_addr_r <= 6'd0;
      crc_r       <= 1'b0;
      phase_r     <= 3'd0;
    end else if (flush) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r     <= ST_RUN;
            addr_r      <= 6'd0;
            last_addr_r <= last_addr_s;
            crc_r       <= rx_crc_ok;
            phase_r     <= rx_best_phase;
          end
        end
        ST_RUN: begin
          if (issue_s) begin
            if (issue_last_s) begin
              state_r <= ST_DRAIN;
            end else begin
              addr_r <= addr_r + 6'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (done_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Tracks each issued read (and whether it is the final octet) until its data returns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe_r  <= {MEM_RD_LATENCY{1'b0}};
      last_pipe_r <= {MEM_RD_LATENCY{1'b0}};
    end else if (flush) begin
      vld_pipe_r  <= {MEM_RD_LATENCY{1'b0}};
      last_pipe_r <= {MEM_RD_LATENCY{1'b0}};
    end else begin
      for (int i = MEM_RD_LATENCY - 1; i > 0; i--) begin
        vld_pipe_r[i]  <= vld_pipe_r[i-1];
        last_pipe_r[i] <= last_pipe_r[i-1];
      end
      vld_pipe_r[0]  <= issue_s;
      last_pipe_r[0] <= issue_s & issue_last_s;
    end
  end

  // Two-entry output FIFO; the head entry drives the stream outputs straight from flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hd_data_r <= 8'd0;
      hd_last_r <= 1'b0;
      hd_vld_r  <= 1'b0;
      tl_data_r <= 8'd0;
      tl_last_r <= 1'b0;
      tl_vld_r  <= 1'b0;
    end else if (flush) begin
      hd_last_r <= 1'b0;
      hd_vld_r  <= 1'b0;
      tl_vld_r  <= 1'b0;
    end else if (pop_s) begin
      if (tl_vld_r) begin
        hd_data_r <= tl_data_r;
        hd_last_r <= tl_last_r;
        tl_vld_r  <= wr_en_s;
        if (wr_en_s) begin
          tl_data_r <= rx_pdu_octet_mem_data;
          tl_last_r <= wr_last_s;
        end
      end else begin
        hd_vld_r <= wr_en_s;
        if (wr_en_s) begin
          hd_data_r <= rx_pdu_octet_mem_data;
          hd_last_r <= wr_last_s;
        end else begin
          hd_last_r <= 1'b0;
        end
      end
    end else if (wr_en_s) begin
      if (hd_vld_r) begin
        tl_data_r <= rx_pdu_octet_mem_data;
        tl_last_r <= wr_last_s;
        tl_vld_r  <= 1'b1;
      end else begin
        hd_data_r <= rx_pdu_octet_mem_data;
        hd_last_r <= wr_last_s;
        hd_vld_r  <= 1'b1;
      end
    end
  end

  // Saturating packet statistics.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_ok_r      <= {CNT_WIDTH{1'b0}};
      cnt_drop_r    <= {CNT_WIDTH{1'b0}};
      cnt_overrun_r <= {CNT_WIDTH{1'b0}};
    end else begin
      if (done_s) begin
        cnt_ok_r <= sat_inc(cnt_ok_r);
      end
      if (drop_s) begin
        cnt_drop_r <= sat_inc(cnt_drop_r);
      end
      if (overrun_s) begin
        cnt_overrun_r <= sat_inc(cnt_overrun_r);
      end
    end
  end

  assign rx_pdu_octet_mem_addr = addr_r;
  assign m_data                = hd_data_r;
  assign m_valid               = hd_vld_r;
  assign m_last                = hd_last_r;
  assign m_crc_ok              = crc_r;
  assign m_best_phase          = phase_r;
  assign busy                  = (state_r != ST_IDLE);
  assign cnt_ok                = cnt_ok_r;
  assign cnt_drop              = cnt_drop_r;
  assign cnt_overrun           = cnt_overrun_r;

endmodule
